// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first through one full-subtractor cell; result valid WIDTH+1 cycles after accept.
// One op in flight: in_ready low from accept until the result handshake completes; the result is held indefinitely under out_ready=0.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Full subtractor built from two half subtractors and an OR.
    logic hs1_dif, hs1_brw, hs2_dif, hs2_brw;
    logic bit_dif, bit_brw;

    always_comb begin
        hs1_dif = a_sh_q[0] ^ b_sh_q[0];
        hs1_brw = ~a_sh_q[0] & b_sh_q[0];
        hs2_dif = hs1_dif ^ br_q;
        hs2_brw = ~hs1_dif & br_q;
        bit_dif = hs2_dif;
        bit_brw = hs1_brw | hs2_brw;
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        diff_d   = diff_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = {bit_dif, res_q[WIDTH-1:1]};
                br_d   = bit_brw;
                cnt_d  = cnt_q + 1'b1;
                // Publish only on the final bit so diff/borrow_out never show a partial result.
                if (cnt_q == LAST) begin
                    cnt_d    = '0;
                    diff_d   = {bit_dif, res_q[WIDTH-1:1]};
                    borrow_d = bit_brw;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q == RUN);
    assign out_valid  = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule
